// File: rtl/pll_lock_seq.sv
// PLL lock synchroniser, core reset hold-off and 1 MHz clock-enable generator.
// Define PLL_LOCK_FILTER_EN to ignore lock drops shorter than four cycles while running.
module pll_lock_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 1024,
    parameter int DIV         = 32
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       sw_reset,
    output logic       core_reset,
    output logic       ready,
    output logic       ce_1m,
    output logic [7:0] relock_cnt
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int DW = $clog2(DIV);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);

    typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [HW-1:0]          r_cnt;
    logic [DW-1:0]          r_div;
    logic                   w_locked_s;
    logic                   w_loss;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
        end
    end

    assign w_locked_s = r_sync[SYNC_STAGES-1];

`ifdef PLL_LOCK_FILTER_EN
    // Counts consecutive low lock samples in RUN; the fourth one is taken as a real loss.
    logic [1:0] r_filt;

    assign w_loss = !w_locked_s && (r_filt == 2'd3);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= '0;
        end else if (r_state == RUN && !w_locked_s && !w_loss) begin
            r_filt <= r_filt + 2'd1;
        end else begin
            r_filt <= '0;
        end
    end
`else
    assign w_loss = !w_locked_s;
`endif

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= WAIT_LOCK;
            r_cnt      <= '0;
            r_div      <= '0;
            core_reset <= 1'b1;
            ready      <= 1'b0;
            ce_1m      <= 1'b0;
            relock_cnt <= '0;
        end else begin
            ce_1m <= 1'b0;
            case (r_state)
                WAIT_LOCK: begin
                    core_reset <= 1'b1;
                    ready      <= 1'b0;
                    r_cnt      <= '0;
                    r_div      <= '0;
                    if (w_locked_s) begin
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    core_reset <= 1'b1;
                    ready      <= 1'b0;
                    r_div      <= '0;
                    if (!w_locked_s) begin
                        r_state <= WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (sw_reset) begin
                        r_cnt <= '0;
                    end else if (r_cnt == HOLD_LAST) begin
                        r_state    <= RUN;
                        r_cnt      <= '0;
                        core_reset <= 1'b0;
                        ready      <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + HW'(1);
                    end
                end
                RUN: begin
                    core_reset <= 1'b0;
                    ready      <= 1'b1;
                    if (w_loss) begin
                        r_state    <= WAIT_LOCK;
                        r_div      <= '0;
                        core_reset <= 1'b1;
                        ready      <= 1'b0;
                        if (relock_cnt != 8'hFF) begin
                            relock_cnt <= relock_cnt + 8'd1;
                        end
                    end else if (sw_reset) begin
                        r_state    <= HOLD;
                        r_cnt      <= '0;
                        r_div      <= '0;
                        core_reset <= 1'b1;
                        ready      <= 1'b0;
                    end else if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        ce_1m <= 1'b1;
                    end else begin
                        r_div <= r_div + DW'(1);
                    end
                end
                default: begin
                    r_state    <= WAIT_LOCK;
                    r_cnt      <= '0;
                    r_div      <= '0;
                    core_reset <= 1'b1;
                    ready      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/pll_lock_seq.md
# pll_lock_seq

Reset and clock-enable sequencer that sits directly downstream of the system PLL. Runs on the PLL's 32 MHz output and synchronises the asynchronous `locked` indication. It holds the core in reset until lock has been stable for a programmable time, then releases `core_reset` and generates a periodic clock-enable strobe for the C64 core's 1 MHz timebase. On lock loss or software reset request it re-enters the reset sequence and counts accepted lock losses.

## Interface
- `SYNC_STAGES`, 2 — flops in the `locked` synchroniser; ≥2.
- `HOLD_CYCLES`, 1024 — cycles lock must be held before release; ≥2.
- `DIV`, 32 — `ce_1m` period in `clk_sys` cycles; ≥2.

- `clk_sys` in 1 — 32 MHz PLL output clock.
- `rst_n` in 1 — asynchronous active-low reset.
- `locked` in 1 — PLL lock, asynchronous to `clk_sys`.
- `sw_reset` in 1 — synchronous reset request, level-sampled each cycle.
- `core_reset` out 1 — active-high reset to core, registered.
- `ready` out 1 — high in RUN, registered.
- `ce_1m` out 1 — one-cycle enable pulse every `DIV` cycles in RUN.
- `relock_cnt` out 8 — accepted lock losses from RUN, saturating at 255.

## Operation
- **Synchroniser:** `locked` passes through `SYNC_STAGES` flops, all reset to 0. Its output is `locked_s`.
- **Hold counter:** width `$clog2(HOLD_CYCLES+1)`.
- **Divider counter:** width `$clog2(DIV)`.
- **States:** WAIT_LOCK, HOLD, RUN.
- **WAIT_LOCK:** `core_reset`=1, `ready`=0. Counters held at 0. Moves to HOLD with cnt=0 on `locked_s`=1.
- **HOLD:** `core_reset`=1. cnt increments each cycle.
  - `locked_s`=0 → WAIT_LOCK. `relock_cnt` does not change.
  - Otherwise `sw_reset`=1 → cnt=0, stay in HOLD.
  - Otherwise cnt==HOLD_CYCLES-1 → RUN.
- **RUN:** `core_reset`=0, `ready`=1. Divider counts 0..DIV-1 and wraps. `ce_1m`=1 in the cycle after the divider reaches DIV-1; the first pulse comes DIV cycles after entering RUN.
  - Accepted lock loss → WAIT_LOCK. `relock_cnt`+1, saturating at 255.
  - Else `sw_reset`=1 → HOLD with cnt=0.
- **Priority:** lock loss > `sw_reset` > count progress.
- **Outputs** derive from the next state and are registered, so they change on the same edge as the state.
- Outside RUN, `ce_1m`=0 and the divider is 0.
- **Reset (`rst_n`=0)** acts immediately, with no clock needed:
  - state=WAIT_LOCK
  - `core_reset`=1, `ready`=0, `ce_1m`=0
  - `relock_cnt`=0
  - all counters and synchroniser flops = 0

## Timing
- **Lock to first decision:** if `locked` rises before edge k, the FSM first sees it at edge k+SYNC_STAGES (HOLD entered).
- **Release:** `core_reset` falls at edge k+SYNC_STAGES+HOLD_CYCLES. The first `ce_1m` is high in the cycle after edge k+SYNC_STAGES+HOLD_CYCLES+DIV.
- **Lock loss (no filter):** if `locked` falls before edge k, `core_reset` rises and `ce_1m` is forced 0 at edge k+SYNC_STAGES.
- **`sw_reset` in RUN:** sampled at edge e, `core_reset`=1 from edge e. It falls at edge e+HOLD_CYCLES, provided `sw_reset` has deasserted.
- **`sw_reset` held high:** keeps HOLD at cnt=0 indefinitely.
- **`rst_n` deassertion:** synchronising `rst_n` deassertion is the parent's responsibility. This block only applies it asynchronously.

## Configuration
- **`PLL_LOCK_FILTER_EN` defined:**
  - In RUN, a 2-bit filter counts consecutive `locked_s`=0 cycles and clears on `locked_s`=1.
  - Loss is accepted only on the 4th consecutive low sample, so WAIT_LOCK is entered 3 edges later than unfiltered.
  - Drops of 1–3 cycles are ignored: no reset, no count, `ce_1m` unaffected.
  - HOLD still reacts to a single low sample.
- **Undefined:** no filter. A single low `locked_s` sample in RUN is an accepted loss.

## Test plan
Parameters for all scenarios: SYNC_STAGES=2, HOLD_CYCLES=16, DIV=32.
- **Power-up:** release `rst_n` with `locked`=1 throughout.
  - `core_reset` falls at edge 18 and `ready` rises at edge 18.
  - `ce_1m` is high in the cycles after edges 50, 82, 114, …
- **Lock loss in RUN, filter undefined:** drop `locked` for 1 cycle.
  - `core_reset`=1 at edge 2 after the drop; `relock_cnt`=1.
  - After relock, release comes 18 edges later.
- **Lock loss in RUN, filter defined:**
  - 3-cycle drop → no change; `relock_cnt`=0.
  - 4-cycle drop → `core_reset`=1 at edge 5; `relock_cnt`=1.
- **Loss in HOLD:** drop `locked` at cnt=10 → WAIT_LOCK. `relock_cnt` is unchanged, and release comes 18 edges after relock.
- **`sw_reset` in RUN:** 1-cycle pulse → `core_reset`=1 for exactly 16 cycles and `ce_1m` stops. `relock_cnt` is unchanged.
- **`sw_reset` plus lock loss:** assert both in the same cycle → WAIT_LOCK and `relock_cnt`+1.
- **Saturation:** 300 lock-loss cycles → `relock_cnt`=255.
- **Async reset:** `rst_n` low mid-RUN with the clock stopped → all outputs return to reset values immediately.
